pe_skew_feeder: RTL and testbench
=================================

PE_SKEW_FEEDER -- requirements
Module: pe_skew_feeder

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ROWS, 8: activation lanes, one per PE array row.
- COLS, 8: weight lanes, one per PE array column.
- DW, 8: lane data width in bits.
- TRAV, ROWS+COLS-1: array traversal cycles appended to the drain.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock; all state changes on its rising edge.
- rst, in, 1: reset, synchronous, active-high.
- s_valid, in, 1: the input vector is valid.
- s_ready, out, 1: the feeder accepts a vector.
- s_last, in, 1: the accepted vector is the last one of the tile.
- s_a, in, ROWS x DW: unskewed activation vector.
- s_w, in, COLS x DW: unskewed weight vector.
- in_a, out, ROWS x DW: skewed activations to the array rows.
- in_w, out, COLS x DW: skewed weights to the array columns.
- fire, out, 1: array enable.
- tile_done, out, 1: one-cycle pulse when the tile has fully drained.

Function
REQ-003 A transfer SHALL occur on a rising edge where s_valid=1 and s_ready=1; no other input vector is consumed.
REQ-004 Activation lane r SHALL be delayed by r+1 cycles from transfer to in_a[r], and weight lane c by c+1 cycles to in_w[c]:
- element 0 is registered once;
- element k passes through k additional stages.
REQ-005 Each lane stage SHALL carry a valid bit, and the output element SHALL be forced to 0 when its valid bit is 0.
REQ-006 A cycle in STREAM with no transfer SHALL inject a zero/invalid bubble into lane stage 0; bubbles propagate with the same skew as data.
REQ-007 FSM states SHALL be IDLE, STREAM and DRAIN.
REQ-008 FSM transitions SHALL be:
- IDLE -> STREAM on a transfer with s_last=0.
- IDLE -> DRAIN on a transfer with s_last=1.
- STREAM -> DRAIN on a transfer with s_last=1.
- DRAIN -> IDLE when the drain counter reaches 0.
REQ-009 s_ready SHALL be 1 in IDLE and STREAM, and 0 in DRAIN.
REQ-010 On DRAIN entry the drain counter SHALL load max(ROWS,COLS)-1+TRAV and decrement by 1 each DRAIN cycle; with defaults it loads 22.
REQ-011 tile_done SHALL be 1 for exactly the DRAIN cycle in which the counter equals 0, and 0 otherwise.
REQ-012 fire SHALL be 1 in STREAM and DRAIN, and 0 in IDLE.
REQ-013 A transfer with s_last=1 while in DRAIN SHALL be impossible, because s_ready=0 in DRAIN; the block ignores s_valid there.
REQ-014 Back-to-back tiles SHALL be supported: the first vector of the next tile is accepted in the cycle after tile_done.
REQ-015 Lane data SHALL pass through unmodified, with no arithmetic on DW-bit values.
REQ-016 The counter width SHALL be $clog2(max(ROWS,COLS)+TRAV+1).

Reset
REQ-017 While rst=1 at a clock edge, the block SHALL:
- enter IDLE;
- clear all lane data and valid bits to 0;
- clear the drain counter;
- drive s_ready=0, fire=0, tile_done=0, in_a=0 and in_w=0 in the following cycle.
REQ-018 s_ready SHALL rise to 1 in the first cycle after rst deasserts.
REQ-019 Reset asserted mid-STREAM or mid-DRAIN SHALL abort the tile with no tile_done pulse, and all in-flight lane data SHALL be discarded.

Structure
REQ-020 A shared package systola_pkg SHALL hold:
- the feeder state enum (IDLE, STREAM, DRAIN);
- the DW default;
- a max-function constant used for the drain load.
REQ-021 A sub-module skew_lane SHALL be used, parameterized by DEPTH and DW.
- It is a shift register of data plus a valid bit with zero-on-invalid output.
- It is instantiated once per activation lane and once per weight lane.
REQ-022 The FSM and drain counter SHALL reside in pe_skew_feeder.

Verification
REQ-023 The bench SHALL cover at least these directed scenarios (ROWS=COLS=8):
- Reset: hold rst for 3 cycles -> outputs, fire, s_ready and tile_done are all 0; s_ready=1 one cycle after release.
- Single vector with s_last=1, s_a[r]=r+1, s_w[c]=0x10+c:
  - in_a[r]=r+1 appears only at cycle r+1 after the transfer, and in_w[c]=0x10+c at cycle c+1;
  - all other cycles drive 0;
  - tile_done pulses 23 cycles after the transfer;
  - fire is high 1..23 cycles after the transfer.
- Ten consecutive vectors with s_a[r]=k for k=1..10, last on k=10:
  - in_a[7] shows 1..10 on cycles 8..17 after the first transfer;
  - s_ready=0 during the 23 DRAIN cycles.
- Bubble: vector A, then s_valid=0 for one cycle, then vector B with last -> every lane shows A, then 0, then B, each at its lane skew.
- rst asserted 5 cycles into DRAIN -> no tile_done, all outputs 0 next cycle, IDLE.
- Back-to-back: tile 2 is offered while tile 1 drains -> accepted in the cycle after tile_done; tile 2's data is never mixed into tile 1's window.

Source files
------------

// File: rtl/systola_pkg.sv
// Shared types and constants for the systolic array feeder.
// Holds the feeder state encoding and sizing helpers.
package systola_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feeder_state_e;

    localparam int DW_DEF = 8;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/skew_lane.sv
// One skew lane: DEPTH-stage data shift register with a valid bit.
// The output is forced to zero whenever its stage is not valid.
module skew_lane
    import systola_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic [DW-1:0] out_data
);

    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            vld_q <= '0;
        end else begin
            data_q[0] <= in_valid ? in_data : '0;
            vld_q[0]  <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i] <= data_q[i-1];
                vld_q[i]  <= vld_q[i-1];
            end
        end
    end

    assign out_data = vld_q[DEPTH-1] ? data_q[DEPTH-1] : '0;

endmodule

// File: rtl/pe_skew_feeder.sv
// Skews activation/weight vectors into a PE array and sequences
// the tile: stream, then drain until the array has emptied.
module pe_skew_feeder
    import systola_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int DW   = DW_DEF,
    parameter int TRAV = ROWS + COLS - 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               s_last,
    input  logic [ROWS*DW-1:0] s_a,
    input  logic [COLS*DW-1:0] s_w,
    output logic [ROWS*DW-1:0] in_a,
    output logic [COLS*DW-1:0] in_w,
    output logic               fire,
    output logic               tile_done
);

    localparam int SPAN = max_of(ROWS, COLS);
    localparam int CW   = $clog2(SPAN + TRAV + 1);
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(SPAN - 1 + TRAV);

    feeder_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready_en_q;
    logic          xfer;

    // ready_en_q holds s_ready low for the cycle right after reset
    assign s_ready   = ready_en_q && (state_q != DRAIN);
    assign xfer      = s_valid && s_ready;
    assign fire      = (state_q != IDLE);
    assign tile_done = (state_q == DRAIN) && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d = s_last ? DRAIN : STREAM;
                    if (s_last) cnt_d = DRAIN_LOAD;
                end
            end
            STREAM: begin
                if (xfer && s_last) begin
                    state_d = DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_a
        skew_lane #(
            .DEPTH(r + 1),
            .DW   (DW)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .in_valid(xfer),
            .in_data (s_a[r*DW +: DW]),
            .out_data(in_a[r*DW +: DW])
        );
    end

    for (genvar c = 0; c < COLS; c++) begin : g_w
        skew_lane #(
            .DEPTH(c + 1),
            .DW   (DW)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .in_valid(xfer),
            .in_data (s_w[c*DW +: DW]),
            .out_data(in_w[c*DW +: DW])
        );
    end

endmodule

// File: tb/tb_pe_skew_feeder.sv
// Scoreboard bench for pe_skew_feeder: directed tiles push expected
// per-cycle frames; a negedge monitor pops and compares them.
module tb_pe_skew_feeder;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int DW   = 8;
    localparam int AW   = ROWS * DW;
    localparam int WIN  = 64;

    logic          clk;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic          s_last;
    logic [AW-1:0] s_a;
    logic [AW-1:0] s_w;
    logic [AW-1:0] in_a;
    logic [AW-1:0] in_w;
    logic          fire;
    logic          tile_done;

    pe_skew_feeder #(
        .ROWS(ROWS),
        .COLS(COLS),
        .DW  (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_last   (s_last),
        .s_a      (s_a),
        .s_w      (s_w),
        .in_a     (in_a),
        .in_w     (in_w),
        .fire     (fire),
        .tile_done(tile_done)
    );

    typedef struct {
        int            cyc;
        logic [AW-1:0] a;
        logic [AW-1:0] w;
        logic          done;
        logic          fire;
        logic          rdy;
    } frame_t;

    frame_t q[$];
    int     cyc = 0;
    int     n_chk = 0;
    int     n_fail = 0;

    logic [AW-1:0] ia [WIN];
    logic [AW-1:0] iw [WIN];
    logic          id [WIN];
    logic          ifi [WIN];
    logic          ir [WIN];
    int            base;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int c,
                       input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, c, act, exp);
        end
    endtask

    always @(negedge clk) begin
        frame_t f;
        if (q.size() > 0 && q[0].cyc <= cyc) begin
            f = q.pop_front();
            if (f.cyc < cyc) begin
                chk("frame_missed", f.cyc, AW'(cyc), AW'(f.cyc));
            end else begin
                chk("in_a", cyc, in_a, f.a);
                chk("in_w", cyc, in_w, f.w);
                chk("tile_done", cyc, AW'(tile_done), AW'(f.done));
                chk("fire", cyc, AW'(fire), AW'(f.fire));
                chk("s_ready", cyc, AW'(s_ready), AW'(f.rdy));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] vec(input logic [7:0] b, input bit inc);
        logic [AW-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++) begin
            v[r*DW +: DW] = b + (inc ? 8'(r) : 8'd0);
        end
        return v;
    endfunction

    task automatic img_clear(input int b);
        base = b;
        for (int i = 0; i < WIN; i++) begin
            ia[i]  = '0;
            iw[i]  = '0;
            id[i]  = 1'b0;
            ifi[i] = 1'b0;
            ir[i]  = 1'b1;
        end
    endtask

    // lane r of a vector transferred at edge t shows at cyc t+r
    task automatic img_vec(input int t, input logic [AW-1:0] a,
                           input logic [AW-1:0] w);
        int idx;
        for (int r = 0; r < ROWS; r++) begin
            idx = t - base + r;
            if (idx >= 0 && idx < WIN) begin
                ia[idx][r*DW +: DW] = a[r*DW +: DW];
                iw[idx][r*DW +: DW] = w[r*DW +: DW];
            end
        end
    endtask

    task automatic img_tile(input int tf, input int tl);
        for (int c = tf; c <= tl + 22; c++) begin
            if (c - base >= 0 && c - base < WIN) ifi[c-base] = 1'b1;
        end
        for (int c = tl; c <= tl + 22; c++) begin
            if (c - base >= 0 && c - base < WIN) ir[c-base] = 1'b0;
        end
        if (tl + 22 - base < WIN) id[tl+22-base] = 1'b1;
    endtask

    task automatic img_push(input int n);
        frame_t f;
        for (int i = 0; i < n; i++) begin
            f.cyc  = base + i;
            f.a    = ia[i];
            f.w    = iw[i];
            f.done = id[i];
            f.fire = ifi[i];
            f.rdy  = ir[i];
            q.push_back(f);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int n;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_a     = '0;
        s_w     = '0;

        // reset held 3 cycles, s_ready rises one cycle after release
        img_clear(1);
        for (int i = 0; i < 3; i++) ir[i] = 1'b0;
        img_push(4);
        repeat (3) step();
        rst = 1'b0;
        step();

        // single vector with last
        t = cyc + 1;
        img_clear(t);
        img_vec(t, vec(8'h01, 1), vec(8'h10, 1));
        img_tile(t, t);
        img_push(30);
        s_valid = 1'b1;
        s_last  = 1'b1;
        s_a     = vec(8'h01, 1);
        s_w     = vec(8'h10, 1);
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_a     = '0;
        s_w     = '0;
        repeat (29) step();

        // ten consecutive vectors, last on the tenth
        t = cyc + 1;
        img_clear(t);
        for (int k = 1; k <= 10; k++) begin
            img_vec(t + k - 1, vec(8'(k), 0), vec(8'(8'h20 + k), 0));
        end
        img_tile(t, t + 9);
        img_push(40);
        for (int k = 1; k <= 10; k++) begin
            s_valid = 1'b1;
            s_last  = (k == 10);
            s_a     = vec(8'(k), 0);
            s_w     = vec(8'(8'h20 + k), 0);
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (30) step();

        // bubble between two vectors
        t = cyc + 1;
        img_clear(t);
        img_vec(t, vec(8'hA0, 1), vec(8'hB0, 1));
        img_vec(t + 2, vec(8'hC0, 1), vec(8'hD0, 1));
        img_tile(t, t + 2);
        img_push(35);
        s_valid = 1'b1;
        s_a     = vec(8'hA0, 1);
        s_w     = vec(8'hB0, 1);
        step();
        s_valid = 1'b0;
        s_a     = vec(8'h55, 0);
        s_w     = vec(8'h66, 0);
        step();
        s_valid = 1'b1;
        s_last  = 1'b1;
        s_a     = vec(8'hC0, 1);
        s_w     = vec(8'hD0, 1);
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (32) step();

        // reset 5 cycles into drain aborts the tile
        t = cyc + 1;
        img_clear(t);
        img_vec(t, vec(8'hE0, 1), vec(8'hF0, 1));
        img_tile(t, t);
        for (int i = 5; i < 30; i++) begin
            ia[i]  = '0;
            iw[i]  = '0;
            id[i]  = 1'b0;
            ifi[i] = 1'b0;
            ir[i]  = (i >= 6);
        end
        img_push(30);
        s_valid = 1'b1;
        s_last  = 1'b1;
        s_a     = vec(8'hE0, 1);
        s_w     = vec(8'hF0, 1);
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (24) step();

        // back-to-back: tile 2 offered while tile 1 drains
        t = cyc + 1;
        img_clear(t);
        img_vec(t, vec(8'h31, 1), vec(8'h41, 1));
        img_tile(t, t);
        img_vec(t + 24, vec(8'h71, 1), vec(8'h81, 1));
        img_tile(t + 24, t + 24);
        img_push(55);
        s_valid = 1'b1;
        s_last  = 1'b1;
        s_a     = vec(8'h31, 1);
        s_w     = vec(8'h41, 1);
        step();
        s_a = vec(8'h71, 1);
        s_w = vec(8'h81, 1);
        n = 0;
        while (!s_ready && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) begin
            n_chk++;
            n_fail++;
            $display("FAIL b2b_accept cyc=%0d got=s_ready_low expected=s_ready_high", cyc);
        end
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_a     = '0;
        s_w     = '0;
        repeat (30) step();

        repeat (3) step();
        chk("queue_drained", cyc, AW'(q.size()), AW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
